lc3_imem_responder: RTL and testbench

//  Instruction-memory responder on the LC3 fetch interface. It samples the fetch

---
 rtl/lc3_pkg.sv | 11 +
 rtl/lc3_imem_lat_pipe.sv | 43 ++++
 rtl/lc3_imem_responder.sv | 65 ++++++
 tb/tb_lc3_imem_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC3 types and constants used by fetch, decode, the instruction
// memory responder and the bench.
package lc3_pkg;

   typedef logic [15:0] word_t;

   localparam word_t LC3_RESET_PC = 16'h3000;
   // BR with no condition bits set: never taken, so it behaves as a NOP.
   localparam word_t LC3_NOP      = 16'h0000;

endpackage

// File: rtl/lc3_imem_lat_pipe.sv
// Fixed-latency {valid, err, data} delay line with synchronous clear.
// Stage 0 is loaded on the acceptance edge and stage LAT drives the outputs,
// so a response appears LAT posedges after it was accepted.
module lc3_imem_lat_pipe
   import lc3_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic  i_clock,
   input  logic  i_reset,
   input  logic  i_vld,
   input  logic  i_err,
   input  word_t i_data,
   output logic  o_vld,
   output logic  o_err,
   output word_t o_data
);

   logic [LAT:0] r_vld_pipe;
   logic [LAT:0] r_err_pipe;
   word_t        r_data_pipe [LAT+1];

   // Shift every stage each cycle; the output data stage only loads when a
   // response arrives so instr_dout holds between responses.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_vld_pipe <= '0;
         r_err_pipe <= '0;
         for (int s = 0; s <= LAT; s++) r_data_pipe[s] <= LC3_NOP;
      end else begin
         r_vld_pipe     <= {r_vld_pipe[LAT-1:0], i_vld};
         r_err_pipe     <= {r_err_pipe[LAT-1:0], i_vld & i_err};
         r_data_pipe[0] <= i_data;
         for (int s = 1; s < LAT; s++) r_data_pipe[s] <= r_data_pipe[s-1];
         if (r_vld_pipe[LAT-1]) r_data_pipe[LAT] <= r_data_pipe[LAT-1];
      end
   end

   assign o_vld  = r_vld_pipe[LAT];
   assign o_err  = r_err_pipe[LAT];
   assign o_data = r_data_pipe[LAT];

endmodule

// File: rtl/lc3_imem_responder.sv
// Instruction-memory responder for the LC3 fetch interface. Holds the word
// array, maps absolute addresses to indices, takes preload writes, and feeds
// captured read data through a fixed-latency pipe toward decode.
module lc3_imem_responder
   import lc3_pkg::*;
#(
   parameter word_t BASE_ADDR    = LC3_RESET_PC,
   parameter int    DEPTH_LOG2   = 8,
   parameter int    READ_LATENCY = 1
) (
   input  logic  i_clock,
   input  logic  i_reset,
   input  word_t i_pc,
   input  logic  i_instrmem_rd,
   input  logic  i_load_en,
   input  word_t i_load_addr,
   input  word_t i_load_data,
   output word_t o_instr_dout,
   output logic  o_instr_valid,
   output logic  o_addr_err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
      $error("lc3_imem_responder: READ_LATENCY must be 1..4");
   end

   word_t r_mem [DEPTH];

   word_t w_rd_idx;
   word_t w_ld_idx;
   logic  w_rd_in_range;
   logic  w_ld_in_range;
   word_t w_rd_data;
   logic  w_accept;

   // Indices wrap mod 2**16, so addresses below BASE_ADDR land far above DEPTH.
   assign w_rd_idx      = i_pc - BASE_ADDR;
   assign w_ld_idx      = i_load_addr - BASE_ADDR;
   assign w_rd_in_range = (w_rd_idx >> DEPTH_LOG2) == '0;
   assign w_ld_in_range = (w_ld_idx >> DEPTH_LOG2) == '0;
   assign w_rd_data     = w_rd_in_range ? r_mem[w_rd_idx[DEPTH_LOG2-1:0]] : LC3_NOP;
   assign w_accept      = i_instrmem_rd & ~i_reset;

   // Preload port: live during reset, never cleared; out-of-range writes dropped.
   // Reads sample the array on the same edge, so they see the pre-write word.
   always_ff @(posedge i_clock) begin
      if (i_load_en && w_ld_in_range) r_mem[w_ld_idx[DEPTH_LOG2-1:0]] <= i_load_data;
   end

   lc3_imem_lat_pipe #(
      .LAT (READ_LATENCY)
   ) u_lat_pipe (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_vld   (w_accept),
      .i_err   (~w_rd_in_range),
      .i_data  (w_rd_data),
      .o_vld   (o_instr_valid),
      .o_err   (o_addr_err),
      .o_data  (o_instr_dout)
   );

endmodule

// File: tb/tb_lc3_imem_responder.sv
// Bench for lc3_imem_responder: two instances (latency 1 and 3) share one
// stimulus stream and are compared every cycle against a per-edge response
// schedule built from the address map and memory image.
module tb_lc3_imem_responder;
   import lc3_pkg::*;

   localparam word_t BASE  = 16'h3000;
   localparam int    LAT_A = 1;
   localparam int    LAT_B = 3;

   logic  clk = 1'b0;
   logic  rst;
   word_t pc;
   logic  rd;
   logic  ld_en;
   word_t ld_addr;
   word_t ld_data;
   word_t dout_a, dout_b;
   logic  vld_a, vld_b, err_a, err_b;

   always #5 clk = ~clk;

   lc3_imem_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(8), .READ_LATENCY(LAT_A)) u_dut_a (
      .i_clock(clk), .i_reset(rst), .i_pc(pc), .i_instrmem_rd(rd),
      .i_load_en(ld_en), .i_load_addr(ld_addr), .i_load_data(ld_data),
      .o_instr_dout(dout_a), .o_instr_valid(vld_a), .o_addr_err(err_a));

   lc3_imem_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(8), .READ_LATENCY(LAT_B)) u_dut_b (
      .i_clock(clk), .i_reset(rst), .i_pc(pc), .i_instrmem_rd(rd),
      .i_load_en(ld_en), .i_load_addr(ld_addr), .i_load_data(ld_data),
      .o_instr_dout(dout_b), .o_instr_valid(vld_b), .o_addr_err(err_b));

   int    nvec   = 0;
   int    nerr   = 0;
   int    edge_n = 0;
   word_t ref_mem [256];
   logic  pv [2][8];
   logic  pe [2][8];
   word_t pd [2][8];
   word_t hold [2];

   function automatic int offs(word_t a);
      return (int'(a) - int'(BASE) + 65536) % 65536;
   endfunction

   function automatic bit in_rng(word_t a);
      return offs(a) < 256;
   endfunction

   task automatic chk(string tag, word_t obs, word_t exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h at edge %0d", tag, obs, exp, edge_n);
      end
   endtask

   // One posedge: update the schedule for this edge, then check both DUTs.
   task automatic tick();
      int    lat;
      int    s;
      logic  ev;
      word_t obs_d;
      logic  obs_v, obs_e;
      for (int k = 0; k < 2; k++) begin
         lat = (k == 0) ? LAT_A : LAT_B;
         if (rst) begin
            for (int j = 0; j < 8; j++) pv[k][j] = 1'b0;
            hold[k] = 16'h0000;
         end else if (rd) begin
            s = (edge_n + lat) % 8;
            pv[k][s] = 1'b1;
            pe[k][s] = !in_rng(pc);
            pd[k][s] = in_rng(pc) ? ref_mem[offs(pc)] : 16'h0000;
         end
      end
      if (ld_en && in_rng(ld_addr)) ref_mem[offs(ld_addr)] = ld_data;
      @(posedge clk);
      #1;
      s = edge_n % 8;
      for (int k = 0; k < 2; k++) begin
         ev = pv[k][s];
         if (ev) hold[k] = pd[k][s];
         obs_v = (k == 0) ? vld_a  : vld_b;
         obs_e = (k == 0) ? err_a  : err_b;
         obs_d = (k == 0) ? dout_a : dout_b;
         chk((k == 0) ? "valid_l1" : "valid_l3", {15'b0, obs_v}, {15'b0, ev});
         chk((k == 0) ? "err_l1"   : "err_l3",   {15'b0, obs_e}, {15'b0, ev & pe[k][s]});
         chk((k == 0) ? "dout_l1"  : "dout_l3",  obs_d, hold[k]);
         pv[k][s] = 1'b0;
      end
      edge_n++;
   endtask

   task automatic req(word_t a);
      rd = 1'b1; pc = a; tick(); rd = 1'b0;
   endtask

   task automatic idle(int n);
      rd = 1'b0; ld_en = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         hold[k] = 16'h0000;
         for (int j = 0; j < 8; j++) begin pv[k][j] = 1'b0; pe[k][j] = 1'b0; pd[k][j] = 16'h0; end
      end
      for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
      rst = 1'b1; pc = BASE; rd = 1'b1; ld_en = 1'b0; ld_addr = BASE; ld_data = 16'h0;

      // Fill the whole image during reset; requests in reset must be ignored.
      ld_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         ld_addr = BASE + word_t'(i); ld_data = word_t'($urandom); pc = ld_addr; tick();
      end
      // Out-of-range loads must not alias into the array.
      ld_addr = 16'h3100; ld_data = 16'hDEAD; tick();
      ld_addr = 16'h2FFF; ld_data = 16'hBEEF; tick();
      ld_addr = 16'h3000; ld_data = 16'h1021; tick();
      ld_addr = 16'h3001; ld_data = 16'h5260; tick();
      ld_addr = 16'h3002; ld_data = 16'h0E02; tick();
      ld_addr = 16'h3003; ld_data = 16'hF025; tick();
      ld_en = 1'b0; rd = 1'b0;
      tick();
      rst = 1'b0;

      // Sequential fetch of the boot image, including the 0xFF/0x00 entries.
      for (int i = 0; i < 4; i++) req(BASE + word_t'(i));
      req(16'h30FF);
      req(16'h3100);
      idle(4);
      chk("t1_last_in_l3", dout_b, 16'h0000);

      // Out-of-range requests on both sides of the window.
      req(16'h2FFF); req(16'h3100); req(16'hFFFF); req(16'h3000);
      idle(4);

      // Same-edge load and read: old word first, new word after.
      ld_en = 1'b1; ld_addr = 16'h3005; ld_data = 16'hAAAA; tick();
      ld_data = 16'h5555; rd = 1'b1; pc = 16'h3005; tick();
      ld_en = 1'b0; tick();
      chk("t3_old_word", dout_a, 16'hAAAA);
      rd = 1'b0; tick();
      chk("t3_new_word", dout_a, 16'h5555);
      idle(4);

      // In-flight response unaffected by a later load.
      req(16'h3010);
      ld_en = 1'b1; ld_addr = 16'h3010; ld_data = 16'h1234; tick();
      idle(4);

      // Reset on the second response edge of the latency-3 instance.
      req(16'h3000); req(16'h3001); req(16'h3002);
      tick();
      rst = 1'b1; rd = 1'b1; tick();
      rst = 1'b0; rd = 1'b0;
      idle(5);
      chk("t4_dout_reset", dout_b, 16'h0000);

      // Branch redirect.
      req(16'h3001); req(16'h3002); req(16'h3040);
      idle(4);

      // No requests while pc toggles.
      for (int i = 0; i < 10; i++) begin
         pc = (i % 2 == 0) ? 16'h3007 : 16'h2000; rd = 1'b0; tick();
      end

      // Randomized traffic with occasional loads and resets.
      for (int i = 0; i < 400; i++) begin
         rd      = ($urandom_range(0, 3) != 0);
         pc      = ($urandom_range(0, 9) == 0) ? word_t'($urandom) : word_t'(16'h2FE0 + $urandom_range(0, 320));
         ld_en   = ($urandom_range(0, 3) == 0);
         ld_addr = ($urandom_range(0, 1) == 0) ? pc : word_t'(16'h2FE0 + $urandom_range(0, 320));
         ld_data = word_t'($urandom);
         rst     = ($urandom_range(0, 29) == 0);
         tick();
      end
      rst = 1'b0;
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
